// File: rtl/pe_noc_endpoint.sv
// rtl/pe_noc_endpoint.sv - PE-side NoC endpoint: address filter, request FIFO, tag FIFO, return-packet egress
module pe_noc_endpoint #(
  parameter int X_SIZE     = 2,
  parameter int Y_SIZE     = 2,
  parameter int PCK_NUM    = 5,
  parameter int DATA_WIDTH = 256,
  parameter int MY_X       = 1,
  parameter int MY_Y       = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          i_valid,
  input  logic [DATA_WIDTH+PCK_NUM+Y_SIZE+X_SIZE-1:0]   i_data,
  output logic                                          o_ready,
  output logic                                          o_valid,
  output logic [DATA_WIDTH+PCK_NUM+Y_SIZE+X_SIZE-1:0]   o_data,
  input  logic                                          i_ready,
  output logic                                          o_pe_valid,
  output logic [DATA_WIDTH-1:0]                         o_pe_data,
  input  logic                                          i_pe_ready,
  input  logic                                          i_pe_valid,
  input  logic [DATA_WIDTH-1:0]                         i_pe_data,
  output logic                                          o_pe_ready,
  output logic [7:0]                                    o_drop_cnt
);

  localparam int TW = DATA_WIDTH + PCK_NUM + Y_SIZE + X_SIZE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = PCK_NUM + DATA_WIDTH;
  localparam logic [X_SIZE-1:0] MY_XV = X_SIZE'(MY_X);
  localparam logic [Y_SIZE-1:0] MY_YV = Y_SIZE'(MY_Y);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // Request FIFO: {pck_no, payload} per entry
  logic [RW-1:0]      req_mem [FIFO_DEPTH];
  logic [AW-1:0]      req_wr;
  logic [AW-1:0]      req_rd;
  logic [AW:0]        req_cnt;

  // Tag FIFO: pck_no of every payload handed to the PE but not yet answered
  logic [PCK_NUM-1:0] tag_mem [FIFO_DEPTH];
  logic [AW-1:0]      tag_wr;
  logic [AW-1:0]      tag_rd;
  logic [AW:0]        tag_cnt;

  logic [TW-1:0]      out_q;
  logic               out_v;
  logic [7:0]         drop_q;

  // Incoming packet fields
  logic [X_SIZE-1:0]     in_x;
  logic [Y_SIZE-1:0]     in_y;
  logic [PCK_NUM-1:0]    in_pck;
  logic [DATA_WIDTH-1:0] in_pay;
  logic                  addr_hit;

  assign in_x     = i_data[X_SIZE-1:0];
  assign in_y     = i_data[X_SIZE +: Y_SIZE];
  assign in_pck   = i_data[X_SIZE+Y_SIZE +: PCK_NUM];
  assign in_pay   = i_data[TW-1 -: DATA_WIDTH];
  assign addr_hit = (in_x == MY_XV) && (in_y == MY_YV);

  logic req_full, req_empty, tag_full, tag_empty;
  logic in_fire, req_push, req_pop, ret_fire;

  assign req_full  = (req_cnt == FULL_CNT);
  assign req_empty = (req_cnt == '0);
  assign tag_full  = (tag_cnt == FULL_CNT);
  assign tag_empty = (tag_cnt == '0);

  // Ready/valid outputs depend only on registered state, reset and i_ready
  assign o_ready    = !reset && !req_full;
  assign o_pe_valid = !req_empty && !tag_full;
  assign o_pe_ready = !tag_empty && (!out_v || i_ready);
  assign o_pe_data  = req_empty ? '0 : req_mem[req_rd][DATA_WIDTH-1:0];
  assign o_valid    = out_v;
  assign o_data     = out_q;
  assign o_drop_cnt = drop_q;

  assign in_fire  = i_valid && o_ready;
  assign req_push = in_fire && addr_hit;
  assign req_pop  = o_pe_valid && i_pe_ready;
  assign ret_fire = i_pe_valid && o_pe_ready;

  // Storage arrays carry no reset; validity comes from the pointers and counts
  always_ff @(posedge clk) begin
    if (req_push) req_mem[req_wr] <= {in_pck, in_pay};
    if (req_pop)  tag_mem[tag_wr] <= req_mem[req_rd][RW-1 -: PCK_NUM];
  end

  // Request FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_wr  <= '0;
      req_rd  <= '0;
      req_cnt <= '0;
    end else begin
      if (req_push) req_wr <= req_wr + 1'b1;
      if (req_pop)  req_rd <= req_rd + 1'b1;
      case ({req_push, req_pop})
        2'b10:   req_cnt <= req_cnt + 1'b1;
        2'b01:   req_cnt <= req_cnt - 1'b1;
        default: req_cnt <= req_cnt;
      endcase
    end
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_wr  <= '0;
      tag_rd  <= '0;
      tag_cnt <= '0;
    end else begin
      if (req_pop)  tag_wr <= tag_wr + 1'b1;
      if (ret_fire) tag_rd <= tag_rd + 1'b1;
      case ({req_pop, ret_fire})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Egress register: a new load wins over a drain, otherwise a drain clears valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v <= 1'b0;
      out_q <= '0;
    end else if (ret_fire) begin
      out_v <= 1'b1;
      out_q <= {i_pe_data, tag_mem[tag_rd], {Y_SIZE{1'b0}}, {X_SIZE{1'b0}}};
    end else if (i_ready) begin
      out_v <= 1'b0;
    end
  end

  // Saturating count of accepted packets not addressed to this endpoint
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= 8'd0;
    end else if (in_fire && !addr_hit && (drop_q != 8'hff)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

endmodule
